// File: rtl/glbl_one_hot.sv
// One-hot checker: registers zero/one-hot/multi-hot flags, lowest set index and popcount.
// Optional latched error flag enabled by defining GLBL_ONE_HOT_STICKY_ERR_EN.
module glbl_one_hot #(
  parameter int INPUT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               valid_in,
  input  logic [INPUT_WIDTH-1:0]             val_in,
  input  logic                               err_clr,
  output logic                               valid_out,
  output logic                               is_one_hot,
  output logic                               is_zero,
  output logic                               multi_hot,
  output logic [$clog2(INPUT_WIDTH)-1:0]     hot_idx,
  output logic [$clog2(INPUT_WIDTH+1)-1:0]   pop_cnt,
  output logic                               sticky_err
);

  localparam int IW = $clog2(INPUT_WIDTH);
  localparam int PW = $clog2(INPUT_WIDTH+1);
  localparam logic [INPUT_WIDTH-1:0] ONE = 1;

  logic          w_zero;
  logic          w_one_hot;
  logic          w_multi;
  logic [IW-1:0] w_idx;
  logic [PW-1:0] w_pop;

  logic          r_valid;
  logic          r_one_hot;
  logic          r_zero;
  logic          r_multi;
  logic [IW-1:0] r_idx;
  logic [PW-1:0] r_pop;

  assign w_zero    = ~|val_in;
  assign w_one_hot = !w_zero && ((val_in & (val_in - ONE)) == '0);
  assign w_multi   = !w_zero && !w_one_hot;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      w_pop = w_pop + PW'(val_in[i]);
    end
  end

  // Scan downward so the last hit is the lowest set bit; zero input leaves index 0.
  always_comb begin
    w_idx = '0;
    for (int i = INPUT_WIDTH-1; i >= 0; i--) begin
      if (val_in[i]) w_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_one_hot <= 1'b0;
      r_zero    <= 1'b1;
      r_multi   <= 1'b0;
      r_idx     <= '0;
      r_pop     <= '0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_one_hot <= w_one_hot;
        r_zero    <= w_zero;
        r_multi   <= w_multi;
        r_idx     <= w_idx;
        r_pop     <= w_pop;
      end
    end
  end

`ifdef GLBL_ONE_HOT_STICKY_ERR_EN
  logic r_sticky;

  // A new error sample wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (valid_in && !w_one_hot) begin
      r_sticky <= 1'b1;
    end else if (err_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign sticky_err = r_sticky;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign sticky_err       = 1'b0;
`endif

  assign valid_out  = r_valid;
  assign is_one_hot = r_one_hot;
  assign is_zero    = r_zero;
  assign multi_hot  = r_multi;
  assign hot_idx    = r_idx;
  assign pop_cnt    = r_pop;

endmodule

// File: tb/tb_glbl_one_hot.sv
// Self-checking bench for glbl_one_hot: directed vector table, random traffic against a
// behavioural model, and hand-written sticky-error/reset sequences.
module tb_glbl_one_hot;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] val_in;
  logic        err_clr;
  logic        valid_out;
  logic        is_one_hot;
  logic        is_zero;
  logic        multi_hot;
  logic [3:0]  hot_idx;
  logic [4:0]  pop_cnt;
  logic        sticky_err;

  int checks = 0;
  int errors = 0;

  glbl_one_hot #(.INPUT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .val_in(val_in), .err_clr(err_clr),
    .valid_out(valid_out), .is_one_hot(is_one_hot), .is_zero(is_zero),
    .multi_hot(multi_hot), .hot_idx(hot_idx), .pop_cnt(pop_cnt), .sticky_err(sticky_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] val;
    logic        e_vout;
    logic        e_oh;
    logic        e_zero;
    logic        e_multi;
    logic [3:0]  e_idx;
    logic [4:0]  e_pop;
  } vec_t;

  vec_t tbl[11];

  // Reference model state: what the outputs should show after the next edge.
  logic        m_vout, m_oh, m_zero, m_multi, m_sticky;
  int          m_idx, m_pop;

`ifdef GLBL_ONE_HOT_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] d, input logic c);
    int pop;
    int low;
    pop = $countones(d);
    low = 0;
    for (int i = W-1; i >= 0; i--) if (d[i]) low = i;
    if (!r) begin
      m_vout = 0; m_oh = 0; m_zero = 1; m_multi = 0; m_idx = 0; m_pop = 0; m_sticky = 0;
    end else begin
      m_vout = v;
      if (v) begin
        m_pop = pop; m_idx = low;
        m_oh = (pop == 1); m_zero = (pop == 0); m_multi = (pop >= 2);
      end
      if (STICKY) begin
        if (v && pop != 1) m_sticky = 1;
        else if (c) m_sticky = 0;
      end else begin
        m_sticky = 0;
      end
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [15:0] d, input logic c);
    rst_n = r; valid_in = v; val_in = d; err_clr = c;
    model_step(r, v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid_out"},  64'(valid_out),  64'(m_vout));
    chk({tag, ".is_one_hot"}, 64'(is_one_hot), 64'(m_oh));
    chk({tag, ".is_zero"},    64'(is_zero),    64'(m_zero));
    chk({tag, ".multi_hot"},  64'(multi_hot),  64'(m_multi));
    chk({tag, ".hot_idx"},    64'(hot_idx),    64'(m_idx));
    chk({tag, ".pop_cnt"},    64'(pop_cnt),    64'(m_pop));
    chk({tag, ".sticky_err"}, 64'(sticky_err), 64'(m_sticky));
  endtask

  initial begin
    logic [15:0] d;
    logic        v, c, r;

    tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1};
    tbl[1]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  5'd1};
    tbl[2]  = '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4,  5'd1};
    tbl[3]  = '{1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 5'd1};
    tbl[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0};
    tbl[5]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  5'd2};
    tbl[6]  = '{1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6,  5'd2};
    tbl[7]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  5'd16};
    tbl[8]  = '{1'b1, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  5'd1};
    tbl[9]  = '{1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd14, 5'd1};
    tbl[10] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14, 5'd1};

    // Reset with a live sample present: it must be discarded.
    rst_n = 0; valid_in = 0; val_in = '0; err_clr = 0;
    m_vout = 0; m_oh = 0; m_zero = 1; m_multi = 0; m_idx = 0; m_pop = 0; m_sticky = 0;
    @(negedge clk);
    apply(1'b0, 1'b1, 16'hFFFF, 1'b0);
    apply(1'b0, 1'b1, 16'h0003, 1'b0);
    chk("rst.valid_out",  64'(valid_out),  64'd0);
    chk("rst.is_one_hot", 64'(is_one_hot), 64'd0);
    chk("rst.is_zero",    64'(is_zero),    64'd1);
    chk("rst.multi_hot",  64'(multi_hot),  64'd0);
    chk("rst.hot_idx",    64'(hot_idx),    64'd0);
    chk("rst.pop_cnt",    64'(pop_cnt),    64'd0);
    chk("rst.sticky_err", 64'(sticky_err), 64'd0);

    // First entry lands on the first edge with reset released.
    for (int k = 0; k < 11; k++) begin
      apply(1'b1, tbl[k].vld, tbl[k].val, 1'b0);
      chk($sformatf("tbl%0d.valid_out", k),  64'(valid_out),  64'(tbl[k].e_vout));
      chk($sformatf("tbl%0d.is_one_hot", k), 64'(is_one_hot), 64'(tbl[k].e_oh));
      chk($sformatf("tbl%0d.is_zero", k),    64'(is_zero),    64'(tbl[k].e_zero));
      chk($sformatf("tbl%0d.multi_hot", k),  64'(multi_hot),  64'(tbl[k].e_multi));
      chk($sformatf("tbl%0d.hot_idx", k),    64'(hot_idx),    64'(tbl[k].e_idx));
      chk($sformatf("tbl%0d.pop_cnt", k),    64'(pop_cnt),    64'(tbl[k].e_pop));
      chk($sformatf("tbl%0d.sticky_err", k), 64'(sticky_err), 64'(m_sticky));
    end

    // Sticky-error sequence: set, hold through one-hot, clear, set-beats-clear, reset.
    apply(1'b1, 1'b1, 16'h0003, 1'b0);
    chk("seq.set",        64'(sticky_err), 64'(STICKY));
    apply(1'b1, 1'b1, 16'h0004, 1'b0);
    apply(1'b1, 1'b1, 16'h0100, 1'b0);
    chk("seq.hold",       64'(sticky_err), 64'(STICKY));
    apply(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("seq.clear",      64'(sticky_err), 64'd0);
    apply(1'b1, 1'b1, 16'h0000, 1'b1);
    chk("seq.set_vs_clr", 64'(sticky_err), 64'(STICKY));
    apply(1'b1, 1'b1, 16'h0020, 1'b0);
    apply(1'b0, 1'b1, 16'h00FF, 1'b1);
    check_model("seq.midrst");
    chk("seq.midrst.is_zero", 64'(is_zero), 64'd1);

    // Randomised traffic against the model, with occasional resets and clears.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: d = 16'(1) << $urandom_range(0, 15);
        1: d = 16'h0000;
        2: d = 16'($urandom);
        default: d = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 49) != 0);
      apply(r, v, d, c);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glbl_one_hot.md
GLBL_ONE_HOT -- requirements
Module: glbl_one_hot

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, giving the width of the checked vector (legal range 2..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  qualifies val_in for sampling this cycle.
REQ-005 SHALL have port val_in  input  INPUT_WIDTH  vector under test.
REQ-006 SHALL have port err_clr  input  1  clears sticky_err; ignored when the sticky-error feature is compiled out.
REQ-007 SHALL have port valid_out  output  1  result fields valid this cycle.
REQ-008 SHALL have port is_one_hot  output  1  exactly one bit set in sampled vector.
REQ-009 SHALL have port is_zero  output  1  no bits set in sampled vector.
REQ-010 SHALL have port multi_hot  output  1  two or more bits set in sampled vector.
REQ-011 SHALL have port hot_idx  output  $clog2(INPUT_WIDTH)  index of the lowest set bit.
REQ-012 SHALL have port pop_cnt  output  $clog2(INPUT_WIDTH+1)  number of set bits.
REQ-013 SHALL have port sticky_err  output  1  latched "non-one-hot sample seen" flag.

Function
REQ-014 SHALL register all outputs, so results appear exactly 1 cycle after the valid_in/val_in sample.
REQ-015 SHALL drive valid_out high in the cycle after valid_in was high, and low otherwise.
REQ-016 SHALL hold is_one_hot, is_zero, multi_hot, hot_idx and pop_cnt at their last values when valid_in is low.
REQ-017 SHALL set exactly one of is_one_hot, is_zero and multi_hot for every sampled vector.
REQ-018 SHALL compute pop_cnt as the full-precision count of ones, e.g. 16 for all-ones at INPUT_WIDTH=16, with no saturation or wrap.
REQ-019 SHALL set hot_idx to the lowest set-bit position when any bit is set, and to 0 when val_in is zero.
REQ-020 SHALL treat bit INPUT_WIDTH-1 as a legal one-hot position.
REQ-021 SHALL compute is_one_hot as "nonzero and (v & (v-1)) == 0", or an equivalent expression.

Reset
REQ-022 SHALL, when rst_n is low at a rising clk edge, clear valid_out, is_one_hot, multi_hot, hot_idx, pop_cnt and sticky_err to 0, and set is_zero to 1.
REQ-023 SHALL give reset priority over valid_in and err_clr, and SHALL discard any sample taken in a cycle where rst_n is low.
REQ-024 SHALL accept valid_in on the first rising edge with rst_n high.

Configuration
REQ-025 SHALL, when macro GLBL_ONE_HOT_STICKY_ERR_EN is defined, set sticky_err on the cycle after any valid sample with is_one_hot=0, and hold it until err_clr or reset.
REQ-026 SHALL, with the macro defined and err_clr high in the same cycle as a new error sample, give the set priority, so sticky_err stays 1.
REQ-027 SHALL, when GLBL_ONE_HOT_STICKY_ERR_EN is undefined, tie sticky_err to constant 0, ignore err_clr, and contain no sticky-error logic.

Verification
REQ-028 SHALL cover this scenario: valid one-hot inputs 0x0001, 0x0002, 0x0010, 0x8000 -> next cycle is_one_hot=1, pop_cnt=1, hot_idx = 0, 1, 4, 15.
REQ-029 SHALL cover this scenario: input 0x0000 -> is_zero=1, is_one_hot=0, pop_cnt=0, hot_idx=0.
REQ-030 SHALL cover this scenario: inputs 0x0003, 0x00C0, 0xFFFF -> multi_hot=1, is_one_hot=0, pop_cnt = 2, 2, 16, hot_idx = 0, 6, 0.
REQ-031 SHALL cover this scenario: inputs 0x0008 and 0x4000 -> is_one_hot=1, hot_idx = 3 and 14.
REQ-032 SHALL cover this scenario: with valid_in low and val_in changed to 0xFFFF -> valid_out=0 and all result fields unchanged.
REQ-033 SHALL cover this scenario: with the macro defined, a valid 0x0003 sample -> sticky_err=1 and stays 1 through later one-hot samples; err_clr pulse -> 0; rst_n low mid-stream -> all outputs at reset values on the next edge.
